// File: rtl/instr_mem_sync.sv
// Clocked, loadable instruction memory: post-reset NOP sweep, PROG write port, 1-cycle fetch.
// Optional per-word even parity when IMEM_PARITY_EN is defined.
module instr_mem_sync #(
  parameter int unsigned INST_ADDR_WIDTH = 9,
  parameter logic [31:0] NOP_WORD        = 32'h00000013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_en,
  input  logic                       prog_we,
  input  logic [INST_ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]                prog_wdata,
  output logic [INST_ADDR_WIDTH:0]   prog_count,
  output logic                       init_done,
  input  logic                       fetch_req,
  input  logic [31:0]                fetch_pc,
  output logic                       fetch_ready,
  output logic                       instr_valid,
  output logic [31:0]                instruction,
`ifdef IMEM_PARITY_EN
  output logic                       parity_err,
`endif
  output logic [1:0]                 instr_fault
);
  localparam int unsigned AW    = INST_ADDR_WIDTH;
  localparam int unsigned DEPTH = 1 << AW;
`ifdef IMEM_PARITY_EN
  localparam int unsigned WW = 33;
`else
  localparam int unsigned WW = 32;
`endif

  typedef enum logic [1:0] {S_INIT, S_RUN, S_PROG} state_t;

  state_t          state;
  logic [AW-1:0]   init_addr;
  logic [WW-1:0]   mem [DEPTH];

  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [31:0]     wr_data;
  logic            fetch_acc;
  logic [1:0]      fault;
  logic [AW-1:0]   rd_idx;
  logic [WW-1:0]   rd_word;
  logic            rd_perr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      init_addr  <= '0;
      init_done  <= 1'b0;
      prog_count <= '0;
    end else begin
      case (state)
        S_INIT: begin
          init_addr <= init_addr + 1'b1;
          if (&init_addr) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end
        end
        S_RUN: if (prog_en) begin
          state      <= S_PROG;
          prog_count <= '0;
        end
        S_PROG: begin
          if (prog_we && prog_count != (AW+1)'(DEPTH))
            prog_count <= prog_count + 1'b1;
          if (!prog_en) state <= S_RUN;
        end
        default: state <= S_INIT;
      endcase
    end
  end

  // The sweep and the PROG port share one write port; they are never active together.
  always_comb begin
    wr_en   = (state == S_INIT) || (state == S_PROG && prog_we);
    wr_addr = (state == S_INIT) ? init_addr : prog_addr;
    wr_data = (state == S_INIT) ? NOP_WORD : prog_wdata;
  end

  always_ff @(posedge clk) begin
`ifdef IMEM_PARITY_EN
    if (wr_en) mem[wr_addr] <= {^wr_data, wr_data};
`else
    if (wr_en) mem[wr_addr] <= wr_data;
`endif
  end

  assign fetch_ready = (state == S_RUN) && !prog_en;
  assign fetch_acc   = fetch_req && fetch_ready;
  assign fault       = {|fetch_pc[31:AW+2], |fetch_pc[1:0]};
  assign rd_idx      = fetch_pc[AW+1:2];
  assign rd_word     = mem[rd_idx];
`ifdef IMEM_PARITY_EN
  assign rd_perr     = ~|fault && ^rd_word;
`else
  assign rd_perr     = 1'b0;
`endif

  // Faulted or corrupted reads return NOP so the core executes a harmless instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instruction <= NOP_WORD;
      instr_fault <= 2'b00;
`ifdef IMEM_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      instr_valid <= fetch_acc;
`ifdef IMEM_PARITY_EN
      parity_err  <= fetch_acc && rd_perr;
`endif
      if (fetch_acc) begin
        instruction <= (|fault || rd_perr) ? NOP_WORD : rd_word[31:0];
        instr_fault <= fault;
      end
    end
  end
endmodule

// File: tb/tb_instr_mem_sync.sv
// Self-checking bench for instr_mem_sync: directed table, corner sequences and a
// randomized run against a mode/array reference model. Parity checks need IMEM_PARITY_EN.
module tb_instr_mem_sync;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int MI = 0, MR = 1, MP = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic prog_en = 1'b0, prog_we = 1'b0, fetch_req = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [31:0] prog_wdata = '0, fetch_pc = '0;
  logic [AW:0] prog_count;
  logic init_done, fetch_ready, instr_valid;
  logic [31:0] instruction;
  logic [1:0] instr_fault;
`ifdef IMEM_PARITY_EN
  logic parity_err;
`endif

  always #5 clk = ~clk;

  instr_mem_sync #(.INST_ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .prog_count(prog_count),
    .init_done(init_done), .fetch_req(fetch_req), .fetch_pc(fetch_pc),
    .fetch_ready(fetch_ready), .instr_valid(instr_valid), .instruction(instruction),
`ifdef IMEM_PARITY_EN
    .parity_err(parity_err),
`endif
    .instr_fault(instr_fault)
  );

  int n_chk = 0, n_err = 0;

  // reference model
  int          m_mode, m_cnt, m_pc;
  logic [31:0] m_mem [DEPTH];
  logic        m_bad [DEPTH];
  logic        m_valid, m_done, m_perr;
  logic [31:0] m_instr;
  logic [1:0]  m_fault;

  typedef struct { logic [31:0] pc; logic [31:0] exp_instr; logic [1:0] exp_fault; } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("instruction", instruction, m_instr);
    chk("instr_fault", 32'(instr_fault), 32'(m_fault));
    chk("init_done", 32'(init_done), 32'(m_done));
    chk("prog_count", 32'(prog_count), 32'(m_pc));
`ifdef IMEM_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  // One clock: inputs already set; checks fetch_ready before the edge, outputs after.
  task automatic cyc();
    logic acc, perr;
    logic [1:0] f;
    logic [31:0] word;
    int idx;
    #1;
    acc = (m_mode == MR) && !prog_en && fetch_req;
    chk("fetch_ready", 32'(fetch_ready), 32'((m_mode == MR) && !prog_en));
    idx  = int'(fetch_pc[AW+1:2]);
    f[0] = (fetch_pc % 4) != 0;
    f[1] = (fetch_pc >> (AW + 2)) != 0;
    perr = (f == 2'b00) && m_bad[idx];
    word = (f != 2'b00 || perr) ? NOP : m_mem[idx];
    @(posedge clk);
    case (m_mode)
      MI: begin
        m_cnt++;
        if (m_cnt == DEPTH) begin
          m_mode = MR; m_done = 1'b1;
          foreach (m_mem[i]) begin m_mem[i] = NOP; m_bad[i] = 1'b0; end
        end
      end
      MR: if (prog_en) begin m_mode = MP; m_pc = 0; end
      default: begin
        if (prog_we) begin
          m_mem[prog_addr] = prog_wdata; m_bad[prog_addr] = 1'b0;
          if (m_pc < DEPTH) m_pc++;
        end
        if (!prog_en) m_mode = MR;
      end
    endcase
    m_valid = acc;
    m_perr  = acc && perr;
    if (acc) begin m_instr = word; m_fault = f; end
    #1;
    check_outputs();
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Called just after a posedge; asserts reset asynchronously, releases after the next edge.
  task automatic do_reset();
    prog_en = 0; prog_we = 0; fetch_req = 0;
    rst_n = 1'b0;
    #1;
    m_mode = MI; m_cnt = 0; m_pc = 0; m_valid = 0; m_done = 0; m_perr = 0;
    m_instr = NOP; m_fault = 2'b00;
    check_outputs();
    chk("fetch_ready_rst", 32'(fetch_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic fetch1(input logic [31:0] pc);
    fetch_req = 1'b1; fetch_pc = pc;
    cyc();
    fetch_req = 1'b0;
  endtask

  task automatic prog_write(input logic [AW-1:0] a, input logic [31:0] d);
    prog_we = 1'b1; prog_addr = a; prog_wdata = d;
    cyc();
    prog_we = 1'b0;
  endtask

  initial begin
    foreach (m_mem[i]) begin m_mem[i] = $urandom; m_bad[i] = 1'b0; end
    tbl[0] = '{32'h4,   32'h00100093, 2'b00};
    tbl[1] = '{32'h8,   32'h00200113, 2'b00};
    tbl[2] = '{32'h3C,  NOP,          2'b00};
    tbl[3] = '{32'h6,   NOP,          2'b01};
    tbl[4] = '{32'h400, NOP,          2'b10};
    tbl[5] = '{32'h402, NOP,          2'b11};
    tbl[6] = '{32'h0,   NOP,          2'b00};

    @(posedge clk); #1;
    do_reset();

    // init sweep: exactly DEPTH cycles
    cycles(DEPTH - 1);
    chk("init_done_early", 32'(init_done), 32'd0);
    cyc();
    chk("init_done_rise", 32'(init_done), 32'd1);
    fetch1(32'h3C);
    chk("fetch_3c_instr", instruction, NOP);
    chk("fetch_3c_valid", 32'(instr_valid), 32'd1);

    // program words 1 and 2
    prog_en = 1'b1; cyc();
    prog_write(4'd1, 32'h00100093);
    prog_write(4'd2, 32'h00200113);
    chk("prog_count_2", 32'(prog_count), 32'd2);
    prog_en = 1'b0; cyc();

    // back-to-back table fetches
    fetch_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      fetch_pc = tbl[i].pc;
      cyc();
      chk("tbl_valid", 32'(instr_valid), 32'd1);
      chk("tbl_instr", instruction, tbl[i].exp_instr);
      chk("tbl_fault", 32'(instr_fault), 32'(tbl[i].exp_fault));
    end
    fetch_req = 1'b0;
    cyc();
    chk("hold_instr", instruction, NOP);
    chk("hold_valid", 32'(instr_valid), 32'd0);

    // prog_en beats fetch_req in the same cycle
    prog_en = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h4;
    cyc();
    chk("conflict_no_valid", 32'(instr_valid), 32'd0);
    prog_en = 1'b0; fetch_req = 1'b0;
    cyc();
    chk("conflict_pc_clear", 32'(prog_count), 32'd0);

    // prog_we in RUN is ignored
    prog_write(4'd1, 32'hDEADBEEF);
    fetch1(32'h4);
    chk("run_we_ignored", instruction, 32'h00100093);

    // prog_count saturation
    prog_en = 1'b1; cyc();
    for (int i = 0; i < DEPTH + 2; i++) prog_write(AW'(i), $urandom);
    chk("prog_count_sat", 32'(prog_count), 32'(DEPTH));
    prog_en = 1'b0; cyc();
    fetch1(32'h0);

    // reset at init address 5
    do_reset();
    cycles(5);
    do_reset();
    cycles(DEPTH - 1);
    chk("reinit_early", 32'(init_done), 32'd0);
    cyc();
    chk("reinit_done", 32'(init_done), 32'd1);

    // reset during PROG
    prog_en = 1'b1; cyc();
    prog_write(4'd1, 32'h12345678);
    do_reset();
    chk("prog_rst_count", 32'(prog_count), 32'd0);
    cycles(DEPTH);
    fetch1(32'h4);
    chk("prog_rst_reinit", instruction, NOP);

`ifdef IMEM_PARITY_EN
    dut.mem[3][0] = ~dut.mem[3][0];
    m_bad[3] = 1'b1;
    fetch1(32'hC);
    chk("parity_flag", 32'(parity_err), 32'd1);
    chk("parity_instr", instruction, NOP);
    cyc();
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      if ($urandom_range(0, 9) == 0) prog_en = ~prog_en;
      prog_we    = $urandom_range(0, 1);
      prog_addr  = AW'($urandom);
      prog_wdata = $urandom;
      fetch_req  = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 7)       fetch_pc = {26'd0, 4'($urandom), 2'b00};
      else if (r == 7) fetch_pc = {26'd0, 4'($urandom), 2'($urandom_range(1, 3))};
      else if (r == 8) fetch_pc = $urandom | 32'h0000_0040;
      else             fetch_pc = $urandom;
      cyc();
    end
    prog_en = 0; prog_we = 0; fetch_req = 0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
